// File: rtl/jtgng_objlinebuf.sv
// Double-banked sprite line buffer: the draw stage fills one bank for the next
// line while the other bank is scanned out (and cleared) for the current line.
module jtgng_objlinebuf #(
  parameter int DW         = 8,
  parameter int AW         = 9,
  parameter int HSIZE      = 256,
  parameter int PALW       = 4,
  parameter int PRIO_FIRST = 0,
  parameter int OBJ_DLY    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen6,
  input  logic          line,
  input  logic          LHBL,
  input  logic          flip,
  input  logic          pxl_we,
  input  logic [AW-1:0] posx,
  input  logic [DW-1:0] new_pxl,
  output logic [DW-1:0] obj_pxl,
  output logic          ovf
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW:0]   HSZ   = (AW+1)'(HSIZE);
  localparam logic [AW-1:0] HLAST = AW'(HSIZE - 1);
  localparam logic [AW-1:0] DLY   = AW'(OBJ_DLY);

  // Bank is the MSB of every index: {bank, address}
  logic [DW-1:0]      ram [0:2*DEPTH-1];
  logic [2*DEPTH-1:0] occ;
  logic [AW-1:0]      cnt;
  logic               line_l;
  logic               lhbl_l;

  function automatic logic is_transparent(input logic [DW-1:0] pxl);
    return &pxl[PALW-1:0];
  endfunction

  logic [AW:0]   wr_idx_p0;
  logic [AW:0]   rd_idx_p0;
  logic [AW-1:0] rd_addr_p0;
  logic          wr_req_p0;
  logic          wr_drop_p0;
  logic          wr_en_p0;
  logic          vld_p0;
  logic          swap_p0;

  // Stage p0: write decode and read address
  always_comb begin
    wr_req_p0  = cen6 & pxl_we;
    wr_idx_p0  = {line, posx};
    wr_drop_p0 = wr_req_p0 & ({1'b0, posx} >= HSZ);
    wr_en_p0   = wr_req_p0 & ~wr_drop_p0 & ~is_transparent(new_pxl)
               & ~((PRIO_FIRST != 0) & occ[wr_idx_p0]);
    rd_addr_p0 = flip ? HLAST - cnt : cnt;
    rd_idx_p0  = {~line, rd_addr_p0};
    // The cen6 where LHBL rises only reloads the counter, so no read then
    vld_p0     = cen6 & LHBL & lhbl_l & ({1'b0, cnt} < HSZ);
    swap_p0    = cen6 & (line != line_l);
  end

  // Stage p1: registered pixel, occupancy and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= '0;
      obj_pxl <= '1;
      ovf     <= 1'b0;
      cnt     <= DLY;
      line_l  <= line;
      lhbl_l  <= 1'b0;
    end else if (cen6) begin
      line_l <= line;
      lhbl_l <= LHBL;
      if (LHBL && !lhbl_l)
        cnt <= DLY;
      else if (LHBL)
        cnt <= cnt + 1'b1;
      if (wr_drop_p0)
        ovf <= 1'b1;
      else if (swap_p0)
        ovf <= 1'b0;
      if (wr_en_p0)
        occ[wr_idx_p0] <= 1'b1;
      if (vld_p0)
        occ[rd_idx_p0] <= 1'b0;
      obj_pxl <= (vld_p0 && occ[rd_idx_p0]) ? ram[rd_idx_p0] : '1;
    end
  end

  // Pixel storage is never cleared; occupancy alone decides visibility
  always_ff @(posedge clk) begin
    if (wr_en_p0 && !rst)
      ram[wr_idx_p0] <= new_pxl;
  end

endmodule

// File: tb/tb_jtgng_objlinebuf.sv
// Bench for jtgng_objlinebuf: two instances (last-wins 8-bit, first-wins 10-bit
// with read delay) driven together and compared against a behavioural line model.
module tb_jtgng_objlinebuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cen6, line, LHBL, flip, pxl_we;
  logic [9:0] posx;
  logic [9:0] new_pxl;
  logic [7:0] obj0;
  logic [9:0] obj1;
  logic       ovf0, ovf1;

  int vectors = 0;
  int errors  = 0;

  jtgng_objlinebuf u0 (
    .clk(clk), .rst(rst), .cen6(cen6), .line(line), .LHBL(LHBL), .flip(flip),
    .pxl_we(pxl_we), .posx(posx[8:0]), .new_pxl(new_pxl[7:0]), .obj_pxl(obj0), .ovf(ovf0)
  );

  jtgng_objlinebuf #(
    .DW(10), .AW(10), .HSIZE(384), .PALW(4), .PRIO_FIRST(1), .OBJ_DLY(3)
  ) u1 (
    .clk(clk), .rst(rst), .cen6(cen6), .line(line), .LHBL(LHBL), .flip(flip),
    .pxl_we(pxl_we), .posx(posx), .new_pxl(new_pxl), .obj_pxl(obj1), .ovf(ovf1)
  );

  wire [19:0] dut_vec = {obj0, ovf0, obj1, ovf1};

  // Reference model: per instance, per bank, per address a stored pixel or -1 (empty)
  int         mem  [2][2][1024];
  int         hs   [2] = '{256, 384};
  int         dly  [2] = '{0, 3};
  int         sz   [2] = '{512, 1024};
  int         mask [2] = '{255, 1023};
  bit         prio [2] = '{1'b0, 1'b1};
  int         mcnt [2];
  bit         mlhbl[2];
  bit         mline[2];
  bit         movf [2];
  logic [9:0] mout [2];

  function automatic logic [19:0] model_vec();
    return {mout[0][7:0], movf[0], mout[1], movf[1]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 1024; a++) mem[i][b][a] = -1;
      mcnt[i]  = dly[i];
      mlhbl[i] = 1'b0;
      mline[i] = line;
      movf[i]  = 1'b0;
      mout[i]  = 10'(mask[i]);
    end
  endtask

  task automatic model_cen();
    int p, px, wb, rb, a;
    bit drop;
    for (int i = 0; i < 2; i++) begin
      p    = int'(posx) % sz[i];
      px   = int'(new_pxl) & mask[i];
      wb   = int'(line);
      rb   = 1 - wb;
      drop = 1'b0;
      if (pxl_we) begin
        if (p >= hs[i]) drop = 1'b1;
        else if ((px & 15) != 15 && !(prio[i] && mem[i][wb][p] >= 0)) mem[i][wb][p] = px;
      end
      if (LHBL && mlhbl[i] && mcnt[i] < hs[i]) begin
        a = flip ? hs[i] - 1 - mcnt[i] : mcnt[i];
        mout[i] = (mem[i][rb][a] < 0) ? 10'(mask[i]) : 10'(mem[i][rb][a]);
        mem[i][rb][a] = -1;
      end else begin
        mout[i] = 10'(mask[i]);
      end
      if (drop) movf[i] = 1'b1;
      else if (line != mline[i]) movf[i] = 1'b0;
      if (LHBL && !mlhbl[i]) mcnt[i] = dly[i];
      else if (LHBL) mcnt[i] = (mcnt[i] + 1) % sz[i];
      mline[i] = line;
      mlhbl[i] = LHBL;
    end
  endtask

  task automatic tick(input bit c6);
    cen6 = c6;
    @(posedge clk);
    if (rst) model_reset();
    else if (c6) model_cen();
    #1;
    cen6 = 1'b0;
  endtask

  task automatic wr(input int x, input int pix);
    posx    = 10'(x);
    new_pxl = 10'(pix);
    pxl_we  = 1'b1;
    tick(1'b1);
    pxl_we  = 1'b0;
  endtask

  // One scan line with random cen6 gaps; reports the first opaque output of each instance
  task automatic run_line(input bit toggle, input int blank, input int active, input int wr_pct,
                          input string name, output int nz0, output int nz1,
                          output int idx0, output int idx1, output logic [9:0] v0, output logic [9:0] v1);
    int c;
    bit c6;
    nz0 = 0; nz1 = 0; idx0 = -1; idx1 = -1; v0 = '1; v1 = '1; c = 0;
    if (toggle) line = ~line;
    while (c < blank + active) begin
      LHBL    = (c >= blank);
      pxl_we  = ($urandom_range(99) < wr_pct);
      posx    = 10'($urandom_range(1023));
      new_pxl = 10'($urandom);
      c6      = ($urandom_range(4) != 0);
      tick(c6);
      vectors++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL %s c=%0d: got %h want %h", name, c, dut_vec, model_vec());
      end
      if (c6) begin
        if (obj0 !== 8'hFF) begin
          if (nz0 == 0) begin idx0 = c - blank; v0 = {2'b00, obj0}; end
          nz0++;
        end
        if (obj1 !== 10'h3FF) begin
          if (nz1 == 0) begin idx1 = c - blank; v1 = obj1; end
          nz1++;
        end
        c++;
      end
    end
    pxl_we = 1'b0;
    LHBL   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; line = 1'b0; LHBL = 1'b0; flip = 1'b0; pxl_we = 1'b0;
    posx = '0; new_pxl = '0; cen6 = 1'b0;
    tick(1'b0);
    tick(1'b0);
    vectors++;
    if (dut_vec !== {8'hFF, 1'b0, 10'h3FF, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", dut_vec, {8'hFF, 1'b0, 10'h3FF, 1'b0});
    end
    rst = 1'b0;
    tick(1'b1);
  endtask

  task automatic test_blank();
    int n0, n1, i0, i1;
    logic [9:0] v0, v1;
    run_line(1'b0, 4, 256, 0, "blank", n0, n1, i0, i1, v0, v1);
    vectors++;
    if (n0 != 0 || n1 != 0) begin
      errors++;
      $display("FAIL blank_count: got %0d/%0d opaque want 0/0", n0, n1);
    end
  endtask

  task automatic test_single_pixel();
    int n0, n1, i0, i1;
    logic [9:0] v0, v1;
    wr(10, 10'h023);
    run_line(1'b1, 3, 400, 0, "single", n0, n1, i0, i1, v0, v1);
    vectors++;
    if (n0 != 1 || i0 != 11 || v0 !== 10'h023 || n1 != 1 || i1 != 8 || v1 !== 10'h023) begin
      errors++;
      $display("FAIL single_slot: got n=%0d/%0d idx=%0d/%0d v=%h/%h want 1/1 11/8 023/023",
               n0, n1, i0, i1, v0, v1);
    end
    run_line(1'b1, 3, 400, 0, "single_other", n0, n1, i0, i1, v0, v1);
    run_line(1'b1, 3, 400, 0, "single_rescan", n0, n1, i0, i1, v0, v1);
    vectors++;
    if (n0 != 0 || n1 != 0) begin
      errors++;
      $display("FAIL clear_on_read: got %0d/%0d opaque want 0/0", n0, n1);
    end
  endtask

  task automatic test_priority();
    int n0, n1, i0, i1;
    logic [9:0] v0, v1;
    wr(5, 10'h012);
    wr(5, 10'h034);
    run_line(1'b1, 3, 400, 0, "prio", n0, n1, i0, i1, v0, v1);
    vectors++;
    if (v0 !== 10'h034 || v1 !== 10'h012 || i0 != 6) begin
      errors++;
      $display("FAIL prio_rule: got %h/%h idx %0d want 034/012 idx 6", v0, v1, i0);
    end
    wr(5, 10'h012);
    wr(5, 10'h04F);
    run_line(1'b1, 3, 400, 0, "prio_transp", n0, n1, i0, i1, v0, v1);
    vectors++;
    if (v0 !== 10'h012 || v1 !== 10'h012 || n0 != 1) begin
      errors++;
      $display("FAIL transparent_write: got %h/%h n=%0d want 012/012 n=1", v0, v1, n0);
    end
  endtask

  task automatic test_flip();
    int n0, n1, i0, i1;
    logic [9:0] v0, v1;
    wr(0, 10'h056);
    flip = 1'b1;
    run_line(1'b1, 3, 400, 0, "flip", n0, n1, i0, i1, v0, v1);
    flip = 1'b0;
    vectors++;
    if (v0 !== 10'h056 || i0 != 256 || v1 !== 10'h056 || i1 != 381) begin
      errors++;
      $display("FAIL flip_slot: got %h@%0d/%h@%0d want 056@256/056@381", v0, i0, v1, i1);
    end
  endtask

  task automatic test_overflow();
    wr(300, 10'h077);
    vectors++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b0 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL ovf_set: got %b/%b want 1/0", ovf0, ovf1);
    end
    line = ~line;
    tick(1'b1);
    vectors++;
    if (ovf0 !== 1'b0 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0", ovf0);
    end
    line = ~line;
    wr(500, 10'h011);
    vectors++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL ovf_drop_on_swap: got %b/%b want 1/1", ovf0, ovf1);
    end
    line = ~line;
    tick(1'b0);
    vectors++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold_no_cen: got %b/%b want 1/1", ovf0, ovf1);
    end
    tick(1'b1);
    vectors++;
    if (ovf0 !== 1'b0 || ovf1 !== 1'b0 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL ovf_clear2: got %b/%b want 0/0", ovf0, ovf1);
    end
  endtask

  task automatic test_mid_reset();
    int n0, n1, i0, i1;
    logic [9:0] v0, v1;
    run_line(1'b1, 2, 400, 0, "clean_a", n0, n1, i0, i1, v0, v1);
    run_line(1'b1, 2, 400, 0, "clean_b", n0, n1, i0, i1, v0, v1);
    wr(3, 10'h2A1);
    wr(20, 10'h155);
    line = ~line;
    tick(1'b1);
    tick(1'b1);
    LHBL = 1'b1;
    tick(1'b1);
    tick(1'b1);
    vectors++;
    if (obj1 !== 10'h2A1 || obj0 !== 8'hFF || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL first_slot_dly: got %h/%h want FF/2A1", obj0, obj1);
    end
    wr(40, 10'h0AA);
    rst = 1'b1;
    tick(1'b0);
    vectors++;
    if (dut_vec !== {8'hFF, 1'b0, 10'h3FF, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got %h want %h", dut_vec, {8'hFF, 1'b0, 10'h3FF, 1'b0});
    end
    rst  = 1'b0;
    LHBL = 1'b0;
    run_line(1'b1, 2, 400, 0, "post_rst_a", n0, n1, i0, i1, v0, v1);
    vectors++;
    if (n0 != 0 || n1 != 0) begin
      errors++;
      $display("FAIL occ_cleared_a: got %0d/%0d opaque want 0/0", n0, n1);
    end
    run_line(1'b1, 2, 400, 0, "post_rst_b", n0, n1, i0, i1, v0, v1);
    vectors++;
    if (n0 != 0 || n1 != 0) begin
      errors++;
      $display("FAIL occ_cleared_b: got %0d/%0d opaque want 0/0", n0, n1);
    end
  endtask

  task automatic test_random();
    int n0, n1, i0, i1;
    logic [9:0] v0, v1;
    for (int k = 0; k < 8; k++) begin
      flip = 1'($urandom_range(1));
      run_line(1'($urandom_range(3) != 0), $urandom_range(2, 10), 400, 30, "random",
               n0, n1, i0, i1, v0, v1);
    end
    flip = 1'b0;
  endtask

  initial begin
    test_reset();
    test_blank();
    test_single_pixel();
    test_priority();
    test_flip();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/jtgng_objlinebuf.md
Name: jtgng_objlinebuf

Overview:
- Parametrised double-banked sprite line buffer; successor to the fixed 8-bit object pixel buffer.
- Sits between the object draw stage and the colour mixer.
- The draw stage writes pixels for the next scan line into one bank while the other bank is scanned out for the current line.
- Adds configurable width and depth, a first/last-writer priority mode, flip readout, a read delay offset, and clear-on-read through per-pixel occupancy bits.

Parameters:
- DW, 8, pixel data width (palette bits plus colour bits).
- AW, 9, line address width.
- HSIZE, 256, visible pixels per line; must be at most 2**AW.
- PALW, 4, number of low colour bits tested for transparency.
- PRIO_FIRST, 0; 1 means the first opaque write to an address wins, 0 means the last write wins.
- OBJ_DLY, 0, initial value of the read counter at line start (pipeline compensation).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cen6  in  1  6 MHz clock enable; all state updates are qualified by it.
- line  in  1  bank select; write bank = line, read bank = ~line.
- LHBL  in  1  horizontal blank, active low; high during active display.
- flip  in  1  mirror the readout horizontally.
- pxl_we  in  1  write strobe from the draw stage.
- posx  in  AW  write X position.
- new_pxl  in  DW  pixel to write.
- obj_pxl  out  DW  pixel to the mixer.
- ovf  out  1  sticky flag: a write was dropped because posx >= HSIZE; cleared on each line toggle.

Behaviour:
- Reset: occupancy bits of both banks = 0; obj_pxl = {DW{1'b1}} (transparent); ovf = 0; read counter = OBJ_DLY; stored line value = line. RAM contents are not cleared, because unoccupied addresses always read as transparent.
- Transparent code: a pixel whose new_pxl[PALW-1:0] is all ones.
- Write (cen6 and pxl_we):
  - posx >= HSIZE: no write; ovf <= 1.
  - Transparent pixel: no write; occupancy unchanged.
  - PRIO_FIRST = 1 and occ[wbank][posx] = 1: write suppressed.
  - Otherwise: ram[wbank][posx] <= new_pxl and occ[wbank][posx] <= 1.
  - Consecutive writes to the same address on successive cen6 follow the priority rule. With PRIO_FIRST = 1 the occupancy bit set by the first write blocks the next one.
- Bank swap: detected on a change of line sampled at cen6.
  - The swap takes effect on that same cen6; a write in that cycle goes to the new write bank.
  - ovf clears on the swap, unless that cycle also drops a write, in which case ovf = 1.
  - No read/write conflict is possible: the write side never touches the read bank.
- Read counter:
  - Loads OBJ_DLY on the cen6 where LHBL is first sampled high after being low.
  - Increments by 1 on every cen6 while LHBL is high.
  - Wraps modulo 2**AW.
- Read address:
  - Counter values >= HSIZE read as transparent.
  - Otherwise the address is cnt when flip = 0, and HSIZE-1-cnt when flip = 1.
- Output:
  - obj_pxl is registered one cen6 after the address is presented.
  - Value = occ ? ram[rbank][addr] : all ones.
  - obj_pxl is forced to all ones on cycles where LHBL was low at address time.
- Clear-on-read: on the same cen6 that a valid address is read, occ[rbank][addr] <= 0, so the bank is clean when it next becomes the write bank.
- Reset asserted mid-line: clears everything as above on the next clk edge, regardless of cen6.
- Without cen6: no state changes and all outputs hold.

Test Plan:
1. Reset, then line = 0 and LHBL = 1 for 256 cen6 -> obj_pxl = 8'hFF on every cycle.
2. line = 0, write posx = 10 with new_pxl = 8'h23; toggle line to 1; LHBL rises with OBJ_DLY = 0 -> obj_pxl = 8'h23 exactly at read slot 10 (one cen6 after address 10), 8'hFF elsewhere. Rescan the same bank after two more toggles without writes -> all 8'hFF (clear-on-read).
3. PRIO_FIRST = 1: write posx = 5 with 8'h12, then 8'h34 -> reads 8'h12. With PRIO_FIRST = 0 the same stimulus -> reads 8'h34. Writing transparent 8'h4F over 8'h12 -> still 8'h12.
4. flip = 1, HSIZE = 256, write posx = 0 with 8'h56 -> obj_pxl = 8'h56 at read slot 255.
5. Write posx = 300 with HSIZE = 256 -> no RAM change and ovf = 1; next line toggle -> ovf = 0. Drop a write in the same cycle as a toggle -> ovf = 1.
6. DW = 10, AW = 10, HSIZE = 384, OBJ_DLY = 3: write posx = 3 with 10'h2A1 -> reads at the first read slot after LHBL rises. Assert rst mid-scan -> obj_pxl = 10'h3FF next clk and all occupancy cleared.
